// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the 2-bit saturating-counter branch predictor.
package branch_predictor_pkg;

    // One table entry: a 2-bit saturating counter; bit 1 is the prediction.
    typedef logic [1:0] ctr2_t;

    localparam ctr2_t STRONG_NT = 2'b00;
    localparam ctr2_t WEAK_NT   = 2'b01;
    localparam ctr2_t WEAK_T    = 2'b10;
    localparam ctr2_t STRONG_T  = 2'b11;

    localparam int DEFAULT_IDX_W = 4;

endpackage : branch_predictor_pkg

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating counter.
// Taken moves toward STRONG_T, not-taken toward STRONG_NT; both ends stick.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic  taken,
    input  ctr2_t cur,
    output ctr2_t nxt
);

    // Saturating step in the direction of the resolved outcome.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != STRONG_T) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != STRONG_NT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PC-indexed table of 2-bit saturating counters,
// combinational prediction, registered training from the EX-stage outcome,
// same-cycle mispredict flag and saturating statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int    IDX_W      = DEFAULT_IDX_W,
    parameter int    PC_W       = 32,
    parameter ctr2_t INIT_STATE = WEAK_T,
    parameter int    CNT_W      = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              predict_valid_in,
    input  logic [PC_W-1:0]   predict_pc_in,
    output logic              predict_taken_out,
    input  logic              update_valid_in,
    input  logic [PC_W-1:0]   update_pc_in,
    input  logic              update_taken_in,
    input  logic              update_predicted_in,
    output logic              mispredict_out,
    output logic [CNT_W-1:0]  branch_cnt_out,
    output logic [CNT_W-1:0]  mispredict_cnt_out
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Word-aligned PCs: the two low bits never select an entry, and upper
    // bits are dropped so distinct branches may alias onto one counter.
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;

    assign pred_idx = predict_pc_in[IDX_W+1:2];
    assign upd_idx  = update_pc_in[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{predict_pc_in[PC_W-1:IDX_W+2], predict_pc_in[1:0],
                              update_pc_in[PC_W-1:IDX_W+2], update_pc_in[1:0]};

    // Registered counter values, gathered for the read mux.
    logic [ENTRIES-1:0][1:0] entries;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        ctr2_t state_q;
        ctr2_t state_nxt;
        logic  hit;

        assign hit = update_valid_in && (upd_idx == IDX_W'(i));

        sat_counter2 u_ctr (
            .taken (update_taken_in),
            .cur   (state_q),
            .nxt   (state_nxt)
        );

        // Entry register: only the addressed entry is written on an update.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                state_q <= INIT_STATE;
            end else if (hit) begin
                state_q <= state_nxt;
            end
        end

        assign entries[i] = state_q;
    end

    // Prediction reads the registered table; an update to the same entry in
    // this cycle is not bypassed, so the pre-update value is seen.
    assign predict_taken_out = predict_valid_in & entries[pred_idx][1];

    // Valid gates everything, so X on the payload with valid low stays harmless.
    assign mispredict_out = update_valid_in && (update_taken_in != update_predicted_in);

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    // Statistics counters, saturating at all-ones rather than wrapping.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (update_valid_in) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict_out && (mispredict_cnt_q != CNT_MAX)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign branch_cnt_out     = branch_cnt_q;
    assign mispredict_cnt_out = mispredict_cnt_q;

endmodule : branch_predictor

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor with a table of 2-bit saturating counters, indexed by PC.
- Sits at the other end of the EX-stage branch decision. It supplies a taken/not-taken prediction to IF/ID and is trained by the resolved outcome (branch && comparison) that EX returns.
- Raises a same-cycle mispredict flag so the pipeline can flush and redirect.
- Keeps saturating statistics counters for branch count and mispredict count.

Parameters:
- IDX_W, 4, index width; table holds 2**IDX_W entries.
- PC_W, 32, PC width.
- INIT_STATE, 2'b10, counter value loaded at reset (weakly taken).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- predict_valid_in  input  1  ID stage holds a branch instruction.
- predict_pc_in  input  PC_W  PC of that branch.
- predict_taken_out  output  1  prediction (1 = taken); 0 when predict_valid_in = 0.
- update_valid_in  input  1  EX stage resolved a branch this cycle.
- update_pc_in  input  PC_W  PC of the resolved branch.
- update_taken_in  input  1  actual decision (1 = taken).
- update_predicted_in  input  1  prediction carried down the pipe with that branch.
- mispredict_out  output  1  update_valid_in && (update_taken_in != update_predicted_in).
- branch_cnt_out  output  CNT_W  resolved branches since reset.
- mispredict_cnt_out  output  CNT_W  mispredictions since reset.

Behaviour:
- Index = pc[IDX_W+1:2]; bits [1:0] are ignored. Aliasing between PCs that share an index is permitted.
- Counter states:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Prediction is counter[idx][1].
- Prediction path is combinational, 0-cycle latency: predict_taken_out = predict_valid_in & ctr[idx][1].
- Update is registered on the rising clk_in edge when update_valid_in = 1:
  - taken: increment, saturating at 11 (11 stays 11).
  - not taken: decrement, saturating at 00 (00 stays 00).
- Only the indexed entry changes; all other entries hold.
- mispredict_out is combinational and valid in the same cycle as the update.
  - Flush and redirect are the pipeline's job, not this block's.
- Statistics, on a clock edge with update_valid_in = 1:
  - branch_cnt_out increments.
  - mispredict_cnt_out increments when mispredict_out = 1.
  - Both saturate at all-ones and never wrap.
- Simultaneous predict and update to the same index: the prediction reflects the pre-update (registered) value. No write-to-read bypass.
- update_valid_in = 0: table and counters hold; mispredict_out = 0.
- Reset (rst_n_in low, asynchronous, any time including mid-update):
  - every entry = INIT_STATE
  - branch_cnt_out = 0, mispredict_cnt_out = 0
  - combinational outputs follow their inputs against the reset table (predict_taken_out = predict_valid_in & INIT_STATE[1]).
- An update in the cycle reset deasserts is applied normally on the next rising edge.
- Inputs with X while their valid is low must not corrupt state.

Decomposition:
- Shared package:
  - counter state constants (STRONG_NT=2'b00, WEAK_NT, WEAK_T, STRONG_T)
  - the 2-bit counter typedef
  - default IDX_W
- One natural sub-module: sat_counter2. It holds the per-entry next-state function (taken_in, cur -> next), instanced or called per table entry.
- Statistics counters stay inline.

Test Plan:
- Reset → all 16 entries predict taken (INIT 10); both stat counters = 0; mispredict_out = 0 with update_valid_in = 0.
- PC 0x40, update not-taken twice (predicted = 1, then 0) → first cycle mispredict_out = 1, second 0. Then prediction for 0x40 = 0, entry = 00, branch_cnt = 2, mispredict_cnt = 1.
- PC 0x40 driven to 00, then one more not-taken → stays 00. Then four taken updates → 01, 10, 11, 11; prediction flips to 1 after the second taken.
- Aliasing: update 0x04 not-taken twice → predicting 0x44 (same index, IDX_W = 4) returns 0; predicting 0x08 is still 1.
- Same-cycle predict and update on PC 0x10 (entry at 10, update not-taken) → predict_taken_out = 1 that cycle, 0 the next.
- Assert rst_n_in low asynchronously mid-cycle after training → entries return to 10 and counters to 0 immediately, without waiting for a clock edge. Force CNT_W = 4 and run 20 updates → branch_cnt_out holds at 15.
